dmi_initiator: RTL and testbench



---
 rtl/dmi_pkg.sv | 40 ++++
 rtl/dmi_if.sv | 29 ++
 rtl/dmi_timeout_ctr.sv | 36 +++
 rtl/dmi_initiator.sv | 144 ++++++++++++++
 tb/tb_dmi_initiator.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg: shared definitions for the DTM-side DMI initiator.
//   - op / status encodings used on the JTAG dmi register and the DMI bus
//   - initiator state enum
//   - request/response structs at the default DMI widths
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    // Request op field (scan-in and DMI request).
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    // Status values (DM response op, dmistat, scan-out op).
    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_FAILED = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP
    } state_e;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] data;
        logic [1:0]            op;
    } dmi_req_t;

    typedef struct packed {
        logic [DMI_DATA_W-1:0] data;
        logic [1:0]            op;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_if.sv
// dmi_if: DMI request/response channel between the DTM (master) and the
// debug module (slave). Valid/ready handshakes complete on the clock edge
// where both are 1.
//   req_valid/req_ready, req_addr, req_data, req_op   master -> slave
//   resp_valid/resp_ready, resp_data, resp_op          slave -> master
interface dmi_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_op;

    modport master (
        output req_valid, req_addr, req_data, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_op
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_op
    );
endinterface

// File: rtl/dmi_timeout_ctr.sv
// dmi_timeout_ctr: response watchdog for the DMI initiator.
//   clock, reset_n  sole clock, synchronous active-low reset
//   enable          count this cycle (initiator is waiting for a response)
//   clear           restart from zero (initiator is not waiting)
//   expire          1 in the cycle whose edge brings the count to TIMEOUT
// TIMEOUT = 0 disables the watchdog. The count saturates and never wraps.
module dmi_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LIMIT)
            count <= count + 1'b1;
    end

    // Fire on the increment that reaches TIMEOUT so the initiator's status
    // changes on that same edge.
    assign expire = (TIMEOUT > 0) && enable && !clear && (count == LAST);
endmodule

// File: rtl/dmi_initiator.sv
// dmi_initiator: DTM side of the Debug Module Interface.
//   clock, reset_n                 sole clock, synchronous active-low reset
//   upd_valid/addr/data/op         Update-DR of the JTAG dmi register
//   cap_valid                      Capture-DR strobe (capture data is always valid)
//   cap_addr/data/op               value loaded into the dmi shift register
//   dmireset, dmihardreset         one-cycle dtmcs controls
//   dmistat                        sticky status: 0 ok, 2 failed, 3 busy
//   dmi                            DMI request/response channel (master side)
module dmi_initiator
    import dmi_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic [1:0]        upd_op,
    input  logic              cap_valid,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [DATA_W-1:0] cap_data,
    output logic [1:0]        cap_op,
    input  logic              dmireset,
    input  logic              dmihardreset,
    output logic [1:0]        dmistat,
    dmi_if.master             dmi
);
    state_e            state, state_n;
    logic [1:0]        stat_q, stat_n;
    logic              discard_q, discard_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] cap_data_q, cap_data_n;
    logic              load_req;
    logic              expire;
    logic              unused_cap_valid;

    // Capture outputs are continuously valid, so the strobe carries no work.
    assign unused_cap_valid = cap_valid;

    dmi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state == S_WAIT_RESP),
        .clear   (state != S_WAIT_RESP),
        .expire  (expire)
    );

    // NOTE: every variable driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        stat_n     = stat_q;
        discard_n  = discard_q;
        cap_data_n = cap_data_q;
        load_req   = 1'b0;

        // A response owed to an abandoned request is swallowed here.
        if (discard_q && dmi.resp_valid)
            discard_n = 1'b0;

        if (dmihardreset) begin
            stat_n  = ST_OK;
            state_n = S_IDLE;
            // Abandoning with a request the DM has accepted (or is accepting
            // now) leaves a response still owed to us.
            if (state == S_WAIT_RESP && !dmi.resp_valid)
                discard_n = 1'b1;
            else if (state == S_SEND && dmi.req_ready)
                discard_n = 1'b1;
        end else begin
            if (dmireset)
                stat_n = ST_OK;
            unique case (state)
                S_IDLE: begin
                    if (upd_valid && stat_n == ST_OK &&
                        (upd_op == OP_READ || upd_op == OP_WRITE)) begin
                        load_req = 1'b1;
                        state_n  = S_SEND;
                    end
                end
                S_SEND: begin
                    if (dmi.req_ready)
                        state_n = S_WAIT_RESP;
                    if (upd_valid && stat_n == ST_OK)
                        stat_n = ST_BUSY;
                end
                S_WAIT_RESP: begin
                    if (dmi.resp_valid && !discard_q) begin
                        state_n    = S_IDLE;
                        cap_data_n = dmi.resp_data;
                        if (dmi.resp_op == ST_FAILED)
                            stat_n = ST_FAILED;
                    end else if (expire) begin
                        state_n   = S_IDLE;
                        stat_n    = ST_FAILED;
                        discard_n = 1'b1;
                    end
                    if (upd_valid && stat_n == ST_OK)
                        stat_n = ST_BUSY;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            stat_q     <= ST_OK;
            discard_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= '0;
            cap_data_q <= '0;
        end else begin
            state      <= state_n;
            stat_q     <= stat_n;
            discard_q  <= discard_n;
            cap_data_q <= cap_data_n;
            if (load_req) begin
                addr_q <= upd_addr;
                data_q <= upd_data;
                op_q   <= upd_op;
            end
        end
    end

    assign dmi.req_valid  = (state == S_SEND);
    assign dmi.req_addr   = addr_q;
    assign dmi.req_data   = data_q;
    assign dmi.req_op     = op_q;
    assign dmi.resp_ready = (state == S_WAIT_RESP) || discard_q;

    assign dmistat  = stat_q;
    assign cap_addr = addr_q;
    assign cap_data = cap_data_q;
    assign cap_op   = (stat_q != ST_OK) ? stat_q :
                      ((state != S_IDLE) ? ST_BUSY : ST_OK);
endmodule

// File: tb/tb_dmi_initiator.sv
// tb_dmi_initiator: randomized self-checking bench for dmi_initiator.
// The bench plays both the TAP (update/capture/dtmcs strobes) and the DM.
// A transaction-level model tracks sticky status, last issued address and
// last captured data; every expectation comes from that model.
module tb_dmi_initiator;
    import dmi_pkg::*;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_addr = '0;
    logic [DATA_W-1:0] upd_data = '0;
    logic [1:0]        upd_op = '0;
    logic              cap_valid = 1'b0;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [1:0]        cap_op;
    logic              dmireset = 1'b0;
    logic              dmihardreset = 1'b0;
    logic [1:0]        dmistat;

    dmi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmi_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .upd_valid    (upd_valid),
        .upd_addr     (upd_addr),
        .upd_data     (upd_data),
        .upd_op       (upd_op),
        .cap_valid    (cap_valid),
        .cap_addr     (cap_addr),
        .cap_data     (cap_data),
        .cap_op       (cap_op),
        .dmireset     (dmireset),
        .dmihardreset (dmihardreset),
        .dmistat      (dmistat),
        .dmi          (bus.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [1:0]        m_stat = 2'd0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_cap_data = '0;

    // Observable snapshot: {cap_op, dmistat, cap_addr, cap_data, req_valid, resp_ready}
    wire [44:0] snap = {cap_op, dmistat, cap_addr, cap_data, bus.req_valid, bus.resp_ready};

    function automatic logic [44:0] exp_snap(input logic in_flight, input logic rv, input logic rr);
        logic [1:0] cop;
        cop = (m_stat != 2'd0) ? m_stat : (in_flight ? 2'd3 : 2'd0);
        return {cop, m_stat, m_addr, m_cap_data, rv, rr};
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_update(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data);
        upd_valid = 1'b1; upd_op = op; upd_addr = addr; upd_data = data;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic pulse_dmireset();
        dmireset = 1'b1;
        step();
        dmireset = 1'b0;
        m_stat = 2'd0;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL dmireset_clear: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
    endtask

    // Full transaction with the bench acting as DM.
    task automatic do_txn(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int rdy_dly, input int rsp_dly,
                          input logic [DATA_W-1:0] rdata, input logic [1:0] rop);
        dmi_req_t exp_req;
        exp_req = '{addr: addr, data: data, op: op};
        pulse_update(op, addr, data);
        m_addr = addr;
        for (int i = 0; i <= rdy_dly; i++) begin
            checks++;
            if ({bus.req_valid, bus.req_addr, bus.req_data, bus.req_op} !== {1'b1, exp_req}) begin
                errors++;
                $display("FAIL req_fields: got %b_%h_%h_%0d expected 1_%h_%h_%0d", bus.req_valid,
                         bus.req_addr, bus.req_data, bus.req_op, exp_req.addr, exp_req.data, exp_req.op);
            end
            if (i == rdy_dly) bus.req_ready = 1'b1;
            step();
        end
        bus.req_ready = 1'b0;
        checks++;
        if (snap !== exp_snap(1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL wait_resp_state: got %h expected %h", snap, exp_snap(1'b1, 1'b0, 1'b1));
        end
        repeat (rsp_dly) step();
        bus.resp_valid = 1'b1; bus.resp_data = rdata; bus.resp_op = rop;
        step();
        bus.resp_valid = 1'b0;
        m_cap_data = rdata;
        if (rop == ST_FAILED) m_stat = ST_FAILED;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL txn_done: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({snap, bus.req_addr, bus.req_data, bus.req_op} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h_%h_%h_%h expected all zero", snap,
                     bus.req_addr, bus.req_data, bus.req_op);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_write();
        do_txn(OP_WRITE, 7'h10, 32'h8000_0001, 0, 0, 32'h0, ST_OK);
        cap_valid = 1'b1;
        step();
        cap_valid = 1'b0;
        checks++;
        if ({cap_op, cap_addr, bus.req_valid} !== {2'd0, 7'h10, 1'b0}) begin
            errors++;
            $display("FAIL write_capture: got op=%0d addr=%h req_valid=%b expected op=0 addr=10 req_valid=0",
                     cap_op, cap_addr, bus.req_valid);
        end
    endtask

    task automatic test_read();
        do_txn(OP_READ, 7'h11, $urandom, 1, 5, 32'h0000_0C82, ST_OK);
        checks++;
        if ({cap_data, cap_op} !== {32'h0000_0C82, 2'd0}) begin
            errors++;
            $display("FAIL read_capture: got data=%h op=%0d expected data=00000c82 op=0", cap_data, cap_op);
        end
    endtask

    task automatic test_nop();
        for (int k = 0; k < 2; k++) begin
            pulse_update((k == 0) ? OP_NOP : OP_RSVD, 7'($urandom), $urandom);
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
                    errors++;
                    $display("FAIL nop_no_request: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
                end
                step();
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [1:0] op, rop;
            op  = ($urandom_range(0, 1) == 0) ? OP_READ : OP_WRITE;
            rop = ($urandom_range(0, 3) == 0) ? ST_FAILED : ST_OK;
            do_txn(op, 7'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, rop);
            if (m_stat != 2'd0) pulse_dmireset();
        end
    endtask

    task automatic test_busy();
        logic [DATA_W-1:0] rd;
        pulse_update(OP_READ, 7'h22, 32'h0);
        m_addr = 7'h22;
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        pulse_update(OP_WRITE, 7'h33, $urandom);
        m_stat = ST_BUSY;
        checks++;
        if (snap !== exp_snap(1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL busy_in_wait: got %h expected %h", snap, exp_snap(1'b1, 1'b0, 1'b1));
        end
        rd = $urandom;
        bus.resp_valid = 1'b1; bus.resp_data = rd; bus.resp_op = ST_OK;
        step();
        bus.resp_valid = 1'b0;
        m_cap_data = rd;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL busy_sticky: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
        pulse_update(OP_WRITE, 7'h44, $urandom);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL busy_ignores_update: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
            end
            step();
        end
        pulse_dmireset();
        do_txn(OP_WRITE, 7'h45, $urandom, 0, 1, $urandom, ST_OK);
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] stale;
        pulse_update(OP_READ, 7'h5A, 32'h0);
        m_addr = 7'h5A;
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        repeat (TIMEOUT - 1) step();
        checks++;
        if (snap !== exp_snap(1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL timeout_early: got %h expected %h", snap, exp_snap(1'b1, 1'b0, 1'b1));
        end
        step();
        m_stat = ST_FAILED;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL timeout_expire: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b1));
        end
        stale = ~m_cap_data;
        bus.resp_valid = 1'b1; bus.resp_data = stale; bus.resp_op = ST_OK;
        step();
        bus.resp_valid = 1'b0;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL timeout_late_resp: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
        pulse_dmireset();
    endtask

    task automatic test_hardreset();
        // In SEND, after a busy update has set status.
        pulse_update(OP_WRITE, 7'h61, $urandom);
        m_addr = 7'h61;
        pulse_update(OP_READ, 7'h62, $urandom);
        m_stat = ST_BUSY;
        checks++;
        if (snap !== exp_snap(1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL busy_in_send: got %h expected %h", snap, exp_snap(1'b1, 1'b1, 1'b0));
        end
        dmihardreset = 1'b1;
        step();
        dmihardreset = 1'b0;
        m_stat = 2'd0;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL hardreset_send: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
        // In WAIT_RESP: the next response must be discarded.
        pulse_update(OP_READ, 7'h63, 32'h0);
        m_addr = 7'h63;
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        dmihardreset = 1'b1;
        step();
        dmihardreset = 1'b0;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL hardreset_wait: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b1));
        end
        bus.resp_valid = 1'b1; bus.resp_data = ~m_cap_data; bus.resp_op = ST_FAILED;
        step();
        bus.resp_valid = 1'b0;
        checks++;
        if (snap !== exp_snap(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL hardreset_discard: got %h expected %h", snap, exp_snap(1'b0, 1'b0, 1'b0));
        end
        do_txn(OP_READ, 7'h64, 32'h0, 0, 0, $urandom, ST_OK);
    endtask

    task automatic test_reset_mid_send();
        pulse_update(OP_WRITE, 7'h7F, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        step();
        checks++;
        if ({snap, bus.req_addr, bus.req_data, bus.req_op} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send: got %h_%h_%h_%h expected all zero", snap,
                     bus.req_addr, bus.req_data, bus.req_op);
        end
        reset_n = 1'b1;
        m_stat = 2'd0; m_addr = '0; m_cap_data = '0;
        step();
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data = '0;
        bus.resp_op = '0;
        test_reset();
        test_write();
        test_read();
        test_nop();
        test_random();
        test_busy();
        test_timeout();
        test_hardreset();
        test_reset_mid_send();
        do_txn(OP_WRITE, 7'h01, $urandom, 2, 3, $urandom, ST_OK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
